// File: rtl/and_or_latch_bist.sv
// Built-in self-test driver for one and_or_latch cell: sweeps 48 vectors
// through transparent and hold phases and records error count and first failure.
module and_or_latch_bist #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             drv_a,
   output logic             drv_b,
   output logic             drv_c,
   output logic             drv_d,
   output logic             drv_en,
   input  logic             dut_f,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_seen,
   output logic [5:0]       first_fail
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(SETTLE_CYCLES);
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, LOAD0, DONE} state_t;

   state_t           state_q;
   logic [5:0]       vec_q;
   logic [CNT_W-1:0] cnt_q;
   logic             drv_a_q, drv_b_q, drv_c_q, drv_d_q, drv_en_q;
   logic             done_q, pass_q, fail_seen_q;
   logic [ERR_W-1:0] err_count_q;
   logic [5:0]       first_fail_q;
   logic             exp_f;

   // Transparent phase expects the AND-OR function; hold phases expect the
   // value captured from the last transparent vector (1 after p=15, 0 after LOAD0).
   always_comb begin
      exp_f = 1'b0;
      case (vec_q[5:4])
         2'b00:   exp_f = (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]);
         2'b01:   exp_f = 1'b1;
         default: exp_f = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vec_q        <= '0;
         cnt_q        <= '0;
         drv_a_q      <= 1'b0;
         drv_b_q      <= 1'b0;
         drv_c_q      <= 1'b0;
         drv_d_q      <= 1'b0;
         drv_en_q     <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_seen_q  <= 1'b0;
         err_count_q  <= '0;
         first_fail_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (state_q == DONE) begin
                  done_q <= 1'b1;
                  pass_q <= (err_count_q == '0);
               end
               if (start) begin
                  state_q      <= DRIVE;
                  vec_q        <= '0;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  fail_seen_q  <= 1'b0;
                  err_count_q  <= '0;
                  first_fail_q <= '0;
               end
            end
            DRIVE: begin
               drv_a_q  <= vec_q[3];
               drv_b_q  <= vec_q[2];
               drv_c_q  <= vec_q[1];
               drv_d_q  <= vec_q[0];
               drv_en_q <= (vec_q[5:4] == 2'b00);
               cnt_q    <= '0;
               state_q  <= (SETTLE_CYCLES > 1) ? SETTLE : CHECK;
            end
            SETTLE: begin
               if (cnt_q == SETTLE_LAST) state_q <= CHECK;
               else                      cnt_q   <= cnt_q + 1'b1;
            end
            CHECK: begin
               if (dut_f != exp_f) begin
                  if (err_count_q != ERR_MAX) err_count_q <= err_count_q + 1'b1;
                  if (!fail_seen_q) begin
                     fail_seen_q  <= 1'b1;
                     first_fail_q <= vec_q;
                  end
               end
               cnt_q <= '0;
               if (vec_q == 6'd31) begin
                  state_q <= LOAD0;
               end else if (vec_q == 6'd47) begin
                  state_q <= DONE;
               end else begin
                  vec_q   <= vec_q + 1'b1;
                  state_q <= DRIVE;
               end
            end
            LOAD0: begin
               // Open the latch on 0000 so the H0 phase has a known 0 to hold.
               drv_a_q  <= 1'b0;
               drv_b_q  <= 1'b0;
               drv_c_q  <= 1'b0;
               drv_d_q  <= 1'b0;
               drv_en_q <= 1'b1;
               if (cnt_q == LOAD_LAST) begin
                  vec_q   <= 6'd32;
                  state_q <= DRIVE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = (state_q == DRIVE) || (state_q == SETTLE) ||
                       (state_q == CHECK) || (state_q == LOAD0);
   assign drv_a      = drv_a_q;
   assign drv_b      = drv_b_q;
   assign drv_c      = drv_c_q;
   assign drv_d      = drv_d_q;
   assign drv_en     = drv_en_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_count_q;
   assign fail_seen  = fail_seen_q;
   assign first_fail = first_fail_q;

endmodule

// File: tb/tb_and_or_latch_bist.sv
// Bench for and_or_latch_bist: drives golden and faulty latch models and
// scores each run's outcome against expectations queued at start.
module tb_and_or_latch_bist;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;

   always #5 clk = ~clk;

   logic       drv_a, drv_b, drv_c, drv_d, drv_en, dut_f;
   logic       busy, done, pass, fail_seen;
   logic [4:0] err_count;
   logic [5:0] first_fail;

   logic       a3, b3, c3, d3, en3, busy3, done3, pass3, fail3;
   logic [2:0] err3;
   logic [5:0] first3;

   logic lat_q;
   always_latch begin
      if (drv_en) lat_q <= (drv_a & drv_b) | (drv_c & drv_d);
   end

   always_comb begin
      case (mode)
         2'd0:    dut_f = lat_q;
         2'd1:    dut_f = 1'b0;
         2'd2:    dut_f = 1'b1;
         default: dut_f = (drv_a & drv_b) | (drv_c & drv_d);
      endcase
   end

   and_or_latch_bist #(.SETTLE_CYCLES(2), .ERR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .drv_a(drv_a), .drv_b(drv_b), .drv_c(drv_c), .drv_d(drv_d), .drv_en(drv_en),
      .dut_f(dut_f), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_seen(fail_seen), .first_fail(first_fail)
   );

   and_or_latch_bist #(.SETTLE_CYCLES(2), .ERR_W(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .drv_a(a3), .drv_b(b3), .drv_c(c3), .drv_d(d3), .drv_en(en3),
      .dut_f(1'b0), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .fail_seen(fail3), .first_fail(first3)
   );

   typedef struct {
      int err;
      int first;
      int fail;
      int pass;
      int done_k;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_miss = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_drv"},   {drv_a, drv_b, drv_c, drv_d, drv_en}, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_pass"},  pass, 0);
      check({tag, "_err"},   err_count, 0);
      check({tag, "_fail"},  fail_seen, 0);
      check({tag, "_first"}, first_fail, 0);
   endtask

   // Drive-value check at the first cycle of each vector (SETTLE_CYCLES=2 timing).
   task automatic check_drv(input int k);
      logic [5:0] vv;
      int         v;
      v = -1;
      if (k >= 1 && k <= 94 && (k - 1) % 3 == 0)     v = (k - 1) / 3;
      if (k >= 100 && k <= 145 && (k - 100) % 3 == 0) v = 32 + (k - 100) / 3;
      if (v >= 0) begin
         vv = 6'(v);
         check($sformatf("drv_v%0d", v), {drv_a, drv_b, drv_c, drv_d, drv_en},
               {vv[3:0], (v < 16) ? 1'b1 : 1'b0});
      end
      if (k >= 97 && k <= 99)
         check($sformatf("load0_k%0d", k), {drv_a, drv_b, drv_c, drv_d, drv_en}, 5'b00001);
   endtask

   task automatic run_test(input logic [1:0] m, input int exp_err, input int exp_first,
                           input int abort_k, input int busy_start_k, input bit chk_drv);
      exp_t e;
      int   done_k;
      bit   aborted;
      mode     = m;
      e.err    = exp_err;
      e.first  = exp_first;
      e.fail   = (exp_err != 0) ? 1 : 0;
      e.pass   = (exp_err == 0) ? 1 : 0;
      e.done_k = 148;
      sb_q.push_back(e);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("done_clr", done, 0);
      check("busy_go", busy, 1);
      done_k  = 0;
      aborted = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == abort_k) begin
            #2 rst_n = 1'b0;
            #1 check_all_zero("abort");
            @(negedge clk) rst_n = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (chk_drv) check_drv(k);
         if (done) begin
            done_k = k;
            break;
         end
         start = (k == busy_start_k);
      end
      start = 1'b0;
      e = sb_q.pop_front();
      if (aborted) return;
      if (done_k == 0) check("done_timeout", done_k, e.done_k);
      check("done_cycle", done_k, e.done_k);
      check("err_count", err_count, e.err);
      check("fail_seen", fail_seen, e.fail);
      check("first_fail", first_fail, e.first);
      check("pass", pass, e.pass);
      check("busy_end", busy, 0);
      if (m == 2'd1) check("err_sat_w3", err3, 7);
      $display("run mode=%0d done_k=%0d err=%0d first=%0d pass=%0d",
               m, done_k, err_count, first_fail, pass);
   endtask

   initial begin
      #12 check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      run_test(2'd0, 0,  0,  0,  0,  1'b1);   // golden latch
      run_test(2'd1, 23, 3,  0,  0,  1'b0);   // stuck at 0
      run_test(2'd2, 25, 0,  0,  0,  1'b0);   // stuck at 1
      run_test(2'd3, 16, 16, 0,  0,  1'b0);   // latch ignores enable
      run_test(2'd1, 0,  0,  62, 0,  1'b0);   // reset at v=20
      run_test(2'd0, 0,  0,  0,  10, 1'b0);   // start while busy ignored
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
